sha256_multiblock_core: RTL and testbench

//   Parametrised successor to the single-block naive SHA-256 compression unit.
//   - Hashes a run of 1..MAX_BLOCKS pre-padded 512-bit blocks. Blocks are streamed in as 32-bit words over a valid/ready handshake.
//   - Chains the intermediate hash between blocks and computes UNROLL rounds per clock.
//   - Sits between the message padder/word source and the digest consumer; H_in is normally the SHA-256 IV.

---
 rtl/sha256_multiblock_core.sv | 254 +++++++++++++++++++++++++
 tb/tb_sha256_multiblock_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_multiblock_core.sv
// -----------------------------------------------------------------------------
// sha256_multiblock_core
//
// Hashes a run of 1..MAX_BLOCKS pre-padded 512-bit blocks. The bench or the
// padder streams the blocks in as 32-bit words. The intermediate hash is
// chained between blocks. COMPUTE executes UNROLL rounds per clock.
//
// Handshake: a word moves on every rising edge where w_valid && w_ready.
// w_ready depends only on the FSM state; it is high exactly in LOAD.
// w_valid may drop for any number of cycles. A word presented while
// w_ready is low stays with the producer.
//
// Parameters
//   MAX_BLOCKS  largest block count per run (larger requests are clamped)
//   UNROLL      rounds per COMPUTE cycle: 1, 2 or 4
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        begin a run (honoured only in IDLE or DONE)
//   block_count  blocks in this run, sampled with start
//   H_in         initial hash H0..H7 (H0 in [255:224]), sampled with start
//   w_data       message word, big-endian, word 0 of each block first
//   w_valid      w_data valid
//   w_ready      core takes a word this cycle
//   H_out        hash registers; the final digest while done=1
//   busy         high in LOAD/COMPUTE/UPDATE
//   done         level, high in DONE
//   dbg_state_o  current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module sha256_multiblock_core #(
    parameter int MAX_BLOCKS = 4,
    parameter int UNROLL     = 1,
    localparam int BCW       = $clog2(MAX_BLOCKS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BCW-1:0]   block_count,
    input  logic [255:0]     H_in,
    input  logic [31:0]      w_data,
    input  logic             w_valid,
    output logic             w_ready,
    output logic [255:0]     H_out,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_UPDATE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Clamp value of block_count, converted once to the port width.
    localparam logic [BCW-1:0] MAX_BC = BCW'(MAX_BLOCKS);
    // rnd_q value at the start of the final COMPUTE cycle.
    localparam logic [6:0] LAST_RND = 7'(64 - UNROLL);
    localparam logic [6:0] RND_STEP = 7'(UNROLL);

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     h_q [8];
    logic [31:0]     h_d [8];
    logic [31:0]     v_q [8];        // working variables a..h
    logic [31:0]     v_d [8];
    logic [31:0]     w_q [16];       // schedule window, w_q[0] = W[t]
    logic [31:0]     w_d [16];
    logic [3:0]      word_cnt_q, word_cnt_d;
    logic [6:0]      rnd_q, rnd_d;
    logic [BCW-1:0]  blocks_left_q, blocks_left_d;

    // Round datapath temporaries
    logic [31:0]     ra, rb, rc, rd, re, rf, rg, rh;
    logic [31:0]     t1, t2, wn;
    logic [31:0]     win [16];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            rnd_q         <= '0;
            blocks_left_q <= '0;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= '0;
                v_q[i] <= '0;
            end
            for (int j = 0; j < 16; j++) begin
                w_q[j] <= '0;
            end
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            rnd_q         <= rnd_d;
            blocks_left_q <= blocks_left_d;
            h_q           <= h_d;
            v_q           <= v_d;
            w_q           <= w_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        w_d           = w_q;
        word_cnt_d    = word_cnt_q;
        rnd_d         = rnd_q;
        blocks_left_d = blocks_left_q;
        ra  = v_q[0];
        rb  = v_q[1];
        rc  = v_q[2];
        rd  = v_q[3];
        re  = v_q[4];
        rf  = v_q[5];
        rg  = v_q[6];
        rh  = v_q[7];
        t1  = '0;
        t2  = '0;
        wn  = '0;
        win = w_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    for (int i = 0; i < 8; i++) begin
                        h_d[i] = H_in[255 - 32*i -: 32];
                    end
                    blocks_left_d = (block_count > MAX_BC) ? MAX_BC : block_count;
                    word_cnt_d    = '0;
                    rnd_d         = '0;
                    // An empty run reports H_in as the digest directly.
                    state_d = (block_count == '0) ? S_DONE : S_LOAD;
                end
            end

            S_LOAD: begin
                if (w_valid) begin
                    // Shift in at the top; after 16 words, w_q[0] is word 0.
                    for (int j = 0; j < 15; j++) begin
                        w_d[j] = w_q[j + 1];
                    end
                    w_d[15]    = w_data;
                    word_cnt_d = word_cnt_q + 4'd1;
                    if (word_cnt_q == 4'd15) begin
                        v_d     = h_q;
                        rnd_d   = '0;
                        state_d = S_COMPUTE;
                    end
                end
            end

            S_COMPUTE: begin
                for (int i = 0; i < UNROLL; i++) begin
                    t1 = rh + bsig1(re) + ((re & rf) ^ (~re & rg))
                       + K_ROM[rnd_q[5:0] + 6'(i)] + win[0];
                    t2 = bsig0(ra) + ((ra & rb) ^ (ra & rc) ^ (rb & rc));
                    rh = rg;
                    rg = rf;
                    rf = re;
                    re = rd + t1;
                    rd = rc;
                    rc = rb;
                    rb = ra;
                    ra = t1 + t2;
                    // W[t+16] from the window holding W[t..t+15]. Words made
                    // during the final rounds are never used.
                    wn = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
                    for (int j = 0; j < 15; j++) begin
                        win[j] = win[j + 1];
                    end
                    win[15] = wn;
                end
                v_d[0] = ra;
                v_d[1] = rb;
                v_d[2] = rc;
                v_d[3] = rd;
                v_d[4] = re;
                v_d[5] = rf;
                v_d[6] = rg;
                v_d[7] = rh;
                w_d    = win;
                rnd_d  = rnd_q + RND_STEP;
                if (rnd_q == LAST_RND) begin
                    state_d = S_UPDATE;
                end
            end

            S_UPDATE: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + v_q[i];
                end
                blocks_left_d = blocks_left_q - BCW'(1);
                word_cnt_d    = '0;
                rnd_d         = '0;
                state_d = (blocks_left_q == BCW'(1)) ? S_DONE : S_LOAD;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_ready     = (state_q == S_LOAD);
    assign busy        = (state_q == S_LOAD) || (state_q == S_COMPUTE) ||
                         (state_q == S_UPDATE);
    assign done        = (state_q == S_DONE);
    assign H_out       = {h_q[0], h_q[1], h_q[2], h_q[3],
                          h_q[4], h_q[5], h_q[6], h_q[7]};
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// -----------------------------------------------------------------------------
// Directed bench for sha256_multiblock_core. Three instances (UNROLL 1, 2, 4)
// share the stimulus. Only the instance picked by sel sees start and w_valid.
// Expected digests are the published FIPS 180-4 examples.
// -----------------------------------------------------------------------------
module tb_sha256_multiblock_core;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_2BLK =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    // ---------------- clock / reset / shared stimulus ----------------
    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start;
    logic [2:0]   block_count;
    logic [255:0] h_in;
    logic [31:0]  w_data;
    logic         w_valid;
    int           sel;

    int           cyc = 0;
    int           start_cyc;
    int           checks = 0;
    int           errors = 0;
    int           lat;
    logic [31:0]  msg [48];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic         wr0, wr1, wr2, bz0, bz1, bz2, dn0, dn1, dn2;
    logic [255:0] ho0, ho1, ho2;
    logic [2:0]   st0, st1, st2;

    sha256_multiblock_core #(.MAX_BLOCKS(4), .UNROLL(1)) dut_u1 (
        .clk(clk), .reset(reset), .start(start && sel == 0),
        .block_count(block_count), .H_in(h_in), .w_data(w_data),
        .w_valid(w_valid && sel == 0), .w_ready(wr0), .H_out(ho0),
        .busy(bz0), .done(dn0), .dbg_state_o(st0));

    sha256_multiblock_core #(.MAX_BLOCKS(4), .UNROLL(2)) dut_u2 (
        .clk(clk), .reset(reset), .start(start && sel == 1),
        .block_count(block_count), .H_in(h_in), .w_data(w_data),
        .w_valid(w_valid && sel == 1), .w_ready(wr1), .H_out(ho1),
        .busy(bz1), .done(dn1), .dbg_state_o(st1));

    sha256_multiblock_core #(.MAX_BLOCKS(4), .UNROLL(4)) dut_u4 (
        .clk(clk), .reset(reset), .start(start && sel == 2),
        .block_count(block_count), .H_in(h_in), .w_data(w_data),
        .w_valid(w_valid && sel == 2), .w_ready(wr2), .H_out(ho2),
        .busy(bz2), .done(dn2), .dbg_state_o(st2));

    logic         cur_ready, cur_busy, cur_done;
    logic [255:0] cur_h;
    logic [2:0]   cur_st;

    always_comb begin
        cur_ready = wr0; cur_busy = bz0; cur_done = dn0; cur_h = ho0; cur_st = st0;
        if (sel == 1) begin
            cur_ready = wr1; cur_busy = bz1; cur_done = dn1; cur_h = ho1; cur_st = st1;
        end else if (sel == 2) begin
            cur_ready = wr2; cur_busy = bz2; cur_done = dn2; cur_h = ho2; cur_st = st2;
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [2:0] bc, input logic [255:0] hin);
        @(negedge clk);
        start       = 1'b1;
        block_count = bc;
        h_in        = hin;
        @(negedge clk);
        start       = 1'b0;
        start_cyc   = cyc;
    endtask

    // Sends msg[base .. base+n-1]. With toggle set, every word is preceded
    // by one cycle with w_valid low.
    task automatic send_words(input int base, input int n, input bit toggle, input string tag);
        bit all_taken = 1'b1;
        for (int k = 0; k < n; k++) begin
            bit taken = 1'b0;
            if (toggle) begin
                w_valid = 1'b0;
                @(negedge clk);
            end
            w_data  = msg[base + k];
            w_valid = 1'b1;
            for (int g = 0; g < 300 && !taken; g++) begin
                if (cur_ready) taken = 1'b1;
                @(negedge clk);
            end
            if (!taken) all_taken = 1'b0;
        end
        w_valid = 1'b0;
        check({tag, "_words_accepted"}, 256'(all_taken), 256'(1));
    endtask

    task automatic wait_done(input string tag, output int latency);
        for (int g = 0; g < 3000 && !cur_done; g++) begin
            @(negedge clk);
        end
        latency = cyc - start_cyc;
        check({tag, "_done"}, 256'(cur_done), 256'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 48; i++) msg[i] = 32'h0;
        // "abc", one padded block
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        // 448-bit message, two padded blocks
        msg[16] = 32'h61626364; msg[17] = 32'h62636465; msg[18] = 32'h63646566;
        msg[19] = 32'h64656667; msg[20] = 32'h65666768; msg[21] = 32'h66676869;
        msg[22] = 32'h6768696a; msg[23] = 32'h68696a6b; msg[24] = 32'h696a6b6c;
        msg[25] = 32'h6a6b6c6d; msg[26] = 32'h6b6c6d6e; msg[27] = 32'h6c6d6e6f;
        msg[28] = 32'h6d6e6f70; msg[29] = 32'h6e6f7071; msg[30] = 32'h80000000;
        msg[47] = 32'h000001c0;

        reset = 1'b1; start = 1'b0; block_count = '0; h_in = '0;
        w_data = '0; w_valid = 1'b0; sel = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",    256'(cur_busy),  256'(0));
        check("rst_done",    256'(cur_done),  256'(0));
        check("rst_w_ready", 256'(cur_ready), 256'(0));
        check("rst_h_out",   cur_h,           256'(0));
        check("rst_state",   256'(cur_st),    256'(0));
        reset = 1'b0;
        @(negedge clk);

        // T1: "abc", UNROLL=1
        do_start(3'd1, IV);
        check("t1_busy_load", 256'(cur_busy), 256'(1));
        send_words(0, 16, 1'b0, "t1");
        wait_done("t1", lat);
        check("t1_digest",  cur_h,       DIG_ABC);
        check("t1_latency", 256'(lat),   256'(81));
        check("t1_busy",    256'(cur_busy),  256'(0));
        check("t1_w_ready", 256'(cur_ready), 256'(0));

        // T2: two-block message, restarted from DONE
        do_start(3'd2, IV);
        check("t2_done_cleared", 256'(cur_done), 256'(0));
        send_words(16, 32, 1'b0, "t2");
        wait_done("t2", lat);
        check("t2_digest",  cur_h,     DIG_2BLK);
        check("t2_latency", 256'(lat), 256'(162));

        // T3: "abc" with w_valid low every other cycle
        do_start(3'd1, IV);
        send_words(0, 16, 1'b1, "t3");
        wait_done("t3", lat);
        check("t3_digest",  cur_h,     DIG_ABC);
        check("t3_latency", 256'(lat), 256'(97));

        // T4: reset in the middle of COMPUTE of the two-block run
        do_start(3'd2, IV);
        send_words(16, 16, 1'b0, "t4");
        repeat (10) @(negedge clk);
        check("t4_in_compute", 256'(cur_st), 256'(2));
        reset = 1'b1;
        @(negedge clk);
        check("t4_busy",    256'(cur_busy),  256'(0));
        check("t4_done",    256'(cur_done),  256'(0));
        check("t4_h_out",   cur_h,           256'(0));
        check("t4_w_ready", 256'(cur_ready), 256'(0));
        reset = 1'b0;
        do_start(3'd1, IV);
        send_words(0, 16, 1'b0, "t4_rerun");
        wait_done("t4_rerun", lat);
        check("t4_rerun_digest", cur_h, DIG_ABC);

        // T5: empty run, then start pulsed while busy
        do_start(3'd0, IV);
        check("t5_empty_done", 256'(cur_done), 256'(1));
        check("t5_empty_h",    cur_h,          IV);
        check("t5_empty_busy", 256'(cur_busy), 256'(0));
        do_start(3'd1, IV);
        send_words(0, 16, 1'b0, "t5");
        check("t5_busy_compute", 256'(cur_busy), 256'(1));
        @(negedge clk);
        start = 1'b1; block_count = 3'd2; h_in = 256'h0;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5", lat);
        check("t5_digest",  cur_h,     DIG_ABC);
        check("t5_latency", 256'(lat), 256'(81));

        // T6: UNROLL=2 instance
        sel = 1;
        do_start(3'd1, IV);
        send_words(0, 16, 1'b0, "u2_t1");
        wait_done("u2_t1", lat);
        check("u2_t1_digest",  cur_h,     DIG_ABC);
        check("u2_t1_latency", 256'(lat), 256'(49));
        do_start(3'd2, IV);
        send_words(16, 32, 1'b0, "u2_t2");
        wait_done("u2_t2", lat);
        check("u2_t2_digest",  cur_h,     DIG_2BLK);
        check("u2_t2_latency", 256'(lat), 256'(98));

        // T6: UNROLL=4 instance
        sel = 2;
        do_start(3'd1, IV);
        send_words(0, 16, 1'b0, "u4_t1");
        wait_done("u4_t1", lat);
        check("u4_t1_digest",  cur_h,     DIG_ABC);
        check("u4_t1_latency", 256'(lat), 256'(33));
        do_start(3'd2, IV);
        send_words(16, 32, 1'b0, "u4_t2");
        wait_done("u4_t2", lat);
        check("u4_t2_digest",  cur_h,     DIG_2BLK);
        check("u4_t2_latency", 256'(lat), 256'(66));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
